xg_rx_checker: RTL and testbench
================================

# xg_rx_checker

Receive-side packet checker for the 10G tester. It sits on the AXI-Stream RX output of `xg_interface`, opposite the data path's packet generator. It consumes every received frame and validates the tester header, sequence continuity and length. It accumulates statistics and one-way latency for readout by the register block.

## Interface
Parameters:
- `C_S_AXIS_DATA_WIDTH`, 256: RX stream data width. Only 256 is supported.
- `C_S_AXIS_TUSER_WIDTH`, 128: RX tuser width. The checker ignores tuser.
- `TIME_STAMP_DWIDTH`, 64: width of the free-running timestamp.

Ports:
- `axi_aclk`  in  1: the single clock.
- `axi_resetn`  in  1: reset, asynchronous, active-low.
- `s_axis_tdata`  in  256: RX beat data, byte 0 = bits [7:0].
- `s_axis_tstrb`  in  32: byte-valid mask. Contiguous from bit 0 on the last beat, all ones otherwise.
- `s_axis_tuser`  in  128: unused.
- `s_axis_tvalid`  in  1 / `s_axis_tready`  out  1 / `s_axis_tlast`  in  1: AXI-Stream handshake.
- `time_stamp`  in  64: shared free-running counter.
- `clear_stats`  in  1: single-cycle pulse that zeroes all statistics.
- `pkt_done`  out  1: one-cycle pulse per completed packet.
- `pkt_err`  out  1: valid with `pkt_done`; set when any check failed.
- `pkt_count`, `err_magic`, `err_seq`, `err_len`  out  32 each: wrapping counters.
- `byte_count`  out  64: wrapping count of received bytes.
- `lat_last`, `lat_min`, `lat_max`  out  64 each: latency in `axi_aclk` ticks.

## Operation
- Header in the first beat:
  - [31:0] magic `0x58475453`
  - [63:32] sequence number
  - [79:64] declared frame length in bytes
  - [143:80] TX timestamp
- State machine:
  - `S_HEAD`: wait for the first beat. On a handshake, capture seq, length, TX timestamp and `time_stamp`. Check magic and set `beat_cnt`=1. If tlast is also set, finish in the same beat. Otherwise go to `S_BODY`.
  - `S_BODY`: increment `beat_cnt` on each handshake. On tlast, finish and return to `S_HEAD`.
- Received length = 32*(beat_cnt-1) + popcount(tstrb of last beat), 16-bit arithmetic.
  - A non-contiguous last-beat tstrb is a length error.
  - Any non-all-ones tstrb on a non-last beat is a length error.
- Sequence check:
  - The first packet after reset or clear only seeds `exp_seq` = seq+1; it is never an error.
  - For later packets, a mismatch increments `err_seq` and then resyncs `exp_seq` = seq+1. `exp_seq` wraps at 2^32.
- Latency = head-beat `time_stamp` − TX timestamp, modulo 2^64.
  - Updated for every packet with a good magic.
  - `lat_min` resets to all ones; `lat_max` resets to 0.
- A packet with a bad magic increments only `err_magic` and `pkt_count`; the sequence and length checks are skipped.
- `s_axis_tready` is 1 whenever the block is out of reset. The checker never backpressures.

## Timing
- Reset values: all counters 0, `lat_min` all ones, `lat_last`/`lat_max` 0, `pkt_done`/`pkt_err`/`s_axis_tready` 0. State is `S_HEAD`, seed flag clear.
- `s_axis_tready` rises on the first edge after reset deasserts.
- `pkt_done`, `pkt_err` and all statistics update on the edge after the tlast handshake, giving 1-cycle latency.
- Back-to-back packets, where a head beat directly follows the tlast beat, are accepted with no bubble.
- When `clear_stats` coincides with a packet completion, the clear wins: that packet's contribution is dropped and the seed flag is cleared. `pkt_done` still pulses.
- Reset asserted mid-packet abandons the packet; no partial statistics are recorded.
- Cycles with tvalid low leave all state unchanged.

## Configuration
- `XG_RX_LATENCY_EN` defined: latency subtraction and the min/max/last registers are built.
- Undefined: `lat_last`, `lat_min` and `lat_max` are tied to 0, and the timestamp capture is removed.

## Structure
- Package `xg_tester_pkg` holds:
  - the magic constant and header field bit offsets
  - the state enum (`S_HEAD`, `S_BODY`)
  - the 64-bit `LAT_INIT_MIN` constant
- Sub-module `xg_keep_to_len` is purely combinational. It takes a 32-bit strobe and returns a 6-bit byte count plus a contiguous flag.

## Test plan
- 10 good packets, seq 0..9, 64 bytes (2 beats) → `pkt_count`=10, all error counters 0, `byte_count`=640.
- 1-beat 20-byte packet (tstrb=`0x000FFFFF`, declared length 20) → `pkt_err`=0, `byte_count`+=20.
- Seq 5, 6, 9, 10 → `err_seq`=1, and only packet 9 reports `pkt_err`.
- Declared length 100, actual 96 bytes → `err_len`=1. Last-beat tstrb `0x0000F0FF` → `err_len` increments.
- TX timestamp 1000 with head-beat `time_stamp` 1250, then 1100/1400 → `lat_last`=300, `lat_min`=250, `lat_max`=300. With the macro undefined, all three stay 0.
- `clear_stats` on the same cycle as a tlast handshake → all counters 0 next cycle, and the next packet is not flagged for a sequence error.

Source files
------------

// File: rtl/xg_tester_pkg.sv
// Shared constants and types for the 10G tester receive checker.
package xg_tester_pkg;

    localparam logic [31:0] XG_MAGIC     = 32'h5847_5453;
    localparam int          HDR_MAGIC_LSB = 0;
    localparam int          HDR_SEQ_LSB   = 32;
    localparam int          HDR_LEN_LSB   = 64;
    localparam int          HDR_TS_LSB    = 80;

    localparam logic [63:0] LAT_INIT_MIN = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        S_HEAD = 1'b0,
        S_BODY = 1'b1
    } rx_state_t;

endpackage

// File: rtl/xg_keep_to_len.sv
// Converts a 32-bit byte strobe into a byte count and a contiguous-from-bit-0 flag.
module xg_keep_to_len (
    input  logic [31:0] strb,
    output logic [5:0]  byte_cnt,
    output logic        contig
);

    always_comb begin
        byte_cnt = '0;
        for (int i = 0; i < 32; i++) begin
            byte_cnt = byte_cnt + {5'd0, strb[i]};
        end
    end

    // A contiguous mask is 2^n-1, so adding one clears every set bit.
    assign contig = ((strb & (strb + 32'd1)) == 32'd0);

endmodule

// File: rtl/xg_rx_checker.sv
// Receive-side packet checker: header, sequence and length validation plus statistics.
// Build option: define XG_RX_LATENCY_EN to include one-way latency measurement.
//
//  state  | meaning
//  S_HEAD | waiting for the first beat of a frame (header beat)
//  S_BODY | inside a frame, counting beats until tlast
module xg_rx_checker
    import xg_tester_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int TIME_STAMP_DWIDTH    = 64
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic [TIME_STAMP_DWIDTH-1:0]      time_stamp,
    input  logic                              clear_stats,
    output logic                              pkt_done,
    output logic                              pkt_err,
    output logic [31:0]                       pkt_count,
    output logic [31:0]                       err_magic,
    output logic [31:0]                       err_seq,
    output logic [31:0]                       err_len,
    output logic [63:0]                       byte_count,
    output logic [63:0]                       lat_last,
    output logic [63:0]                       lat_min,
    output logic [63:0]                       lat_max
);

    rx_state_t   state;
    logic [15:0] beat_cnt_q;
    logic [31:0] seq_q;
    logic [15:0] len_q;
    logic        magic_ok_q;
    logic        strb_err_q;
    logic        seeded_q;
    logic [31:0] exp_seq_q;

    logic        hs, head, last_hs;
    logic        cur_magic_ok, strb_contig, strb_full, seq_err, len_err;
    logic [31:0] cur_seq;
    logic [15:0] cur_len, prior_beats, rx_len;
    logic [5:0]  strb_bytes;

    xg_keep_to_len u_keep_to_len (
        .strb     (s_axis_tstrb),
        .byte_cnt (strb_bytes),
        .contig   (strb_contig)
    );

    assign hs      = s_axis_tvalid & s_axis_tready;
    assign head    = (state == S_HEAD);
    assign last_hs = hs & s_axis_tlast;

    // On a head beat the header fields come straight from the bus so 1-beat frames finish in place.
    assign cur_magic_ok = head ? (s_axis_tdata[HDR_MAGIC_LSB +: 32] == XG_MAGIC) : magic_ok_q;
    assign cur_seq      = head ? s_axis_tdata[HDR_SEQ_LSB +: 32] : seq_q;
    assign cur_len      = head ? s_axis_tdata[HDR_LEN_LSB +: 16] : len_q;
    assign prior_beats  = head ? 16'd0 : beat_cnt_q;
    assign strb_full    = &s_axis_tstrb;

    assign rx_len  = {prior_beats[10:0], 5'd0} + {10'd0, strb_bytes};
    assign len_err = (!head && strb_err_q) || !strb_contig || (rx_len != cur_len);
    assign seq_err = seeded_q && (cur_seq != exp_seq_q);

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state         <= S_HEAD;
            s_axis_tready <= 1'b0;
            beat_cnt_q    <= '0;
            seq_q         <= '0;
            len_q         <= '0;
            magic_ok_q    <= 1'b0;
            strb_err_q    <= 1'b0;
            seeded_q      <= 1'b0;
            exp_seq_q     <= '0;
            pkt_done      <= 1'b0;
            pkt_err       <= 1'b0;
            pkt_count     <= '0;
            err_magic     <= '0;
            err_seq       <= '0;
            err_len       <= '0;
            byte_count    <= '0;
        end else begin
            s_axis_tready <= 1'b1;
            pkt_done      <= 1'b0;
            pkt_err       <= 1'b0;

            if (hs) begin
                if (head) begin
                    seq_q      <= cur_seq;
                    len_q      <= cur_len;
                    magic_ok_q <= cur_magic_ok;
                    beat_cnt_q <= 16'd1;
                    strb_err_q <= !s_axis_tlast && !strb_full;
                end else begin
                    beat_cnt_q <= beat_cnt_q + 16'd1;
                    strb_err_q <= strb_err_q || (!s_axis_tlast && !strb_full);
                end
                state <= s_axis_tlast ? S_HEAD : S_BODY;
            end

            if (last_hs) begin
                pkt_done  <= 1'b1;
                pkt_err   <= !cur_magic_ok || seq_err || len_err;
                pkt_count <= pkt_count + 32'd1;
                if (!cur_magic_ok) begin
                    err_magic <= err_magic + 32'd1;
                end else begin
                    if (seq_err) err_seq <= err_seq + 32'd1;
                    if (len_err) err_len <= err_len + 32'd1;
                    byte_count <= byte_count + {48'd0, rx_len};
                    seeded_q   <= 1'b1;
                    exp_seq_q  <= cur_seq + 32'd1;
                end
            end

            // Placed last so a clear coinciding with completion discards that packet.
            if (clear_stats) begin
                pkt_count  <= '0;
                err_magic  <= '0;
                err_seq    <= '0;
                err_len    <= '0;
                byte_count <= '0;
                seeded_q   <= 1'b0;
            end
        end
    end

`ifdef XG_RX_LATENCY_EN
    logic [63:0] lat_q, cur_lat;
    logic        unused_ok;

    assign cur_lat   = head ? (time_stamp - s_axis_tdata[HDR_TS_LSB +: 64]) : lat_q;
    assign unused_ok = ^{s_axis_tuser, s_axis_tdata[C_S_AXIS_DATA_WIDTH-1:HDR_TS_LSB+64]};

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            lat_q    <= '0;
            lat_last <= '0;
            lat_min  <= LAT_INIT_MIN;
            lat_max  <= '0;
        end else begin
            if (hs && head) lat_q <= cur_lat;
            if (last_hs && cur_magic_ok) begin
                lat_last <= cur_lat;
                if (cur_lat < lat_min) lat_min <= cur_lat;
                if (cur_lat > lat_max) lat_max <= cur_lat;
            end
            if (clear_stats) begin
                lat_last <= '0;
                lat_min  <= LAT_INIT_MIN;
                lat_max  <= '0;
            end
        end
    end
`else
    logic unused_ok;

    assign unused_ok = ^{s_axis_tuser, time_stamp,
                         s_axis_tdata[C_S_AXIS_DATA_WIDTH-1:HDR_LEN_LSB+16]};
    assign lat_last  = '0;
    assign lat_min   = '0;
    assign lat_max   = '0;
`endif

endmodule

// File: tb/tb_xg_rx_checker.sv
// Directed bench for xg_rx_checker with a pkt_err scoreboard and a statistics reference model.
module tb_xg_rx_checker;

    localparam logic [31:0] MAGIC = 32'h5847_5453;
    localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          axi_aclk = 1'b0;
    logic          axi_resetn;
    logic [255:0]  s_axis_tdata;
    logic [31:0]   s_axis_tstrb;
    logic [127:0]  s_axis_tuser;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [63:0]   time_stamp;
    logic          clear_stats;
    logic          pkt_done, pkt_err;
    logic [31:0]   pkt_count, err_magic, err_seq, err_len;
    logic [63:0]   byte_count, lat_last, lat_min, lat_max;

    int checks = 0;
    int errors = 0;
    int dones  = 0;
    int pushed = 0;
    bit sb_q[$];

    // reference model state
    logic [31:0] m_pkt, m_emagic, m_eseq, m_elen, m_exp;
    logic [63:0] m_bytes, m_llast, m_lmin, m_lmax;
    bit          m_seeded;

    always #5 axi_aclk = ~axi_aclk;

    xg_rx_checker dut (
        .axi_aclk      (axi_aclk),
        .axi_resetn    (axi_resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .time_stamp    (time_stamp),
        .clear_stats   (clear_stats),
        .pkt_done      (pkt_done),
        .pkt_err       (pkt_err),
        .pkt_count     (pkt_count),
        .err_magic     (err_magic),
        .err_seq       (err_seq),
        .err_len       (err_len),
        .byte_count    (byte_count),
        .lat_last      (lat_last),
        .lat_min       (lat_min),
        .lat_max       (lat_max)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pkt = '0; m_emagic = '0; m_eseq = '0; m_elen = '0; m_bytes = '0;
        m_llast = '0; m_lmin = ALL1; m_lmax = '0; m_seeded = 1'b0; m_exp = '0;
    endtask

    task automatic check_stats(input string step);
        chk({step, ":pkt_count"},  {32'd0, pkt_count},  {32'd0, m_pkt});
        chk({step, ":err_magic"},  {32'd0, err_magic},  {32'd0, m_emagic});
        chk({step, ":err_seq"},    {32'd0, err_seq},    {32'd0, m_eseq});
        chk({step, ":err_len"},    {32'd0, err_len},    {32'd0, m_elen});
        chk({step, ":byte_count"}, byte_count, m_bytes);
`ifdef XG_RX_LATENCY_EN
        chk({step, ":lat_last"}, lat_last, m_llast);
        chk({step, ":lat_min"},  lat_min,  m_lmin);
        chk({step, ":lat_max"},  lat_max,  m_lmax);
`else
        chk({step, ":lat_last"}, lat_last, 64'd0);
        chk({step, ":lat_min"},  lat_min,  64'd0);
        chk({step, ":lat_max"},  lat_max,  64'd0);
`endif
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        clear_stats   = 1'b0;
        repeat (n) @(negedge axi_aclk);
    endtask

    task automatic pulse_clear();
        s_axis_tvalid = 1'b0;
        clear_stats   = 1'b1;
        @(negedge axi_aclk);
        clear_stats   = 1'b0;
        model_clear();
    endtask

    // Drives one frame starting at a negedge and returns at the negedge after its tlast edge,
    // leaving the last beat on the bus so the caller can chain a back-to-back frame.
    task automatic send_pkt(input logic [31:0] magic, input logic [31:0] seq,
                            input logic [15:0] decl, input int nbytes,
                            input logic [31:0] strb_ovr, input logic [63:0] tx_ts,
                            input logic [63:0] rx_ts, input bit clr_last, input bit gap);
        int          nbeats, rem;
        logic [31:0] lstrb;
        logic [15:0] rxlen;
        logic [63:0] lat;
        bit          contig, seqerr, lenerr, err;
        logic [255:0] d;

        nbeats = (nbytes + 31) / 32;
        if (nbeats == 0) nbeats = 1;
        rem   = nbytes - 32 * (nbeats - 1);
        lstrb = (rem >= 32) ? 32'hFFFF_FFFF : ((32'd1 << rem) - 32'd1);
        if (strb_ovr != 32'd0) lstrb = strb_ovr;
        rxlen  = 16'(32 * (nbeats - 1) + $countones(lstrb));
        contig = 1'b1;
        for (int i = 1; i < 32; i++)
            if (lstrb[i] && !lstrb[i-1]) contig = 1'b0;
        lat = rx_ts - tx_ts;

        err = 1'b0;
        if (magic != MAGIC) begin
            err = 1'b1;
            if (!clr_last) begin m_pkt++; m_emagic++; end
        end else begin
            seqerr = m_seeded && (seq != m_exp);
            lenerr = !contig || (rxlen != decl);
            err    = seqerr || lenerr;
            if (!clr_last) begin
                m_pkt++;
                if (seqerr) m_eseq++;
                if (lenerr) m_elen++;
                m_bytes  = m_bytes + {48'd0, rxlen};
                m_llast  = lat;
                if (lat < m_lmin) m_lmin = lat;
                if (lat > m_lmax) m_lmax = lat;
                m_seeded = 1'b1;
                m_exp    = seq + 32'd1;
            end
        end
        if (clr_last) model_clear();
        sb_q.push_back(err);
        pushed++;

        for (int b = 0; b < nbeats; b++) begin
            for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
            if (b == 0) begin
                d[31:0]   = magic;
                d[63:32]  = seq;
                d[79:64]  = decl;
                d[143:80] = tx_ts;
            end
            s_axis_tdata  = d;
            s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
            s_axis_tstrb  = (b == nbeats - 1) ? lstrb : 32'hFFFF_FFFF;
            s_axis_tlast  = (b == nbeats - 1);
            time_stamp    = rx_ts + 64'(b * 7);
            clear_stats   = clr_last && (b == nbeats - 1);
            s_axis_tvalid = 1'b1;
            @(negedge axi_aclk);
            if (gap && b == 0 && nbeats > 1) begin
                s_axis_tvalid = 1'b0;
                time_stamp    = 64'hDEAD;
                @(negedge axi_aclk);
            end
        end
        clear_stats = 1'b0;
    endtask

    // Scoreboard consumer: every completion pops one expected pkt_err.
    always @(negedge axi_aclk) begin
        if (pkt_done === 1'b1) begin
            dones++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_done: observed pkt_done with empty scoreboard, expected none");
            end else begin
                chk("pkt_err", {63'd0, pkt_err}, {63'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axi_resetn    = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        time_stamp    = '0;
        clear_stats   = 1'b0;
        model_clear();

        // reset values
        repeat (3) @(negedge axi_aclk);
        chk("rst:tready", {63'd0, s_axis_tready}, 64'd0);
        chk("rst:pkt_done", {63'd0, pkt_done}, 64'd0);
        check_stats("rst");
`ifdef XG_RX_LATENCY_EN
        chk("rst:lat_min_ones", lat_min, ALL1);
`endif
        axi_resetn = 1'b1;
        chk("rst:tready_hold", {63'd0, s_axis_tready}, 64'd0);
        @(negedge axi_aclk);
        chk("rst:tready_rise", {63'd0, s_axis_tready}, 64'd1);

        // ten good back-to-back 64-byte packets, one with a mid-packet valid gap
        for (int i = 0; i < 10; i++)
            send_pkt(MAGIC, i, 16'd64, 64, 32'd0, 64'd100, 64'd150 + 64'(i), 1'b0, i == 3);
        idle(2);
        check_stats("good10");
        chk("good10:pkt_count", {32'd0, pkt_count}, 64'd10);
        chk("good10:byte_count", byte_count, 64'd640);

        // single-beat 20-byte frame
        send_pkt(MAGIC, 32'd10, 16'd20, 20, 32'd0, 64'd0, 64'd40, 1'b0, 1'b0);
        idle(2);
        check_stats("short20");
        chk("short20:byte_count", byte_count, 64'd660);

        // sequence gap 5,6,9,10
        pulse_clear();
        check_stats("clear1");
        send_pkt(MAGIC, 32'd5,  16'd64, 64, 32'd0, 64'd0, 64'd1, 1'b0, 1'b0);
        send_pkt(MAGIC, 32'd6,  16'd64, 64, 32'd0, 64'd0, 64'd1, 1'b0, 1'b0);
        send_pkt(MAGIC, 32'd9,  16'd64, 64, 32'd0, 64'd0, 64'd1, 1'b0, 1'b0);
        send_pkt(MAGIC, 32'd10, 16'd64, 64, 32'd0, 64'd0, 64'd1, 1'b0, 1'b0);
        idle(2);
        check_stats("seq");
        chk("seq:err_seq", {32'd0, err_seq}, 64'd1);

        // length errors: short frame and non-contiguous last strobe
        send_pkt(MAGIC, 32'd11, 16'd100, 96, 32'd0, 64'd0, 64'd1, 1'b0, 1'b0);
        idle(1);
        chk("len:err_len_short", {32'd0, err_len}, 64'd1);
        send_pkt(MAGIC, 32'd12, 16'd44, 64, 32'h0000_F0FF, 64'd0, 64'd1, 1'b0, 1'b0);
        idle(2);
        check_stats("len");
        chk("len:err_len_noncontig", {32'd0, err_len}, 64'd2);

        // latency
        pulse_clear();
        send_pkt(MAGIC, 32'd0, 16'd64, 64, 32'd0, 64'd1000, 64'd1250, 1'b0, 1'b0);
        send_pkt(MAGIC, 32'd1, 16'd64, 64, 32'd0, 64'd1100, 64'd1400, 1'b0, 1'b0);
        idle(2);
        check_stats("lat");
`ifdef XG_RX_LATENCY_EN
        chk("lat:last", lat_last, 64'd300);
        chk("lat:min",  lat_min,  64'd250);
        chk("lat:max",  lat_max,  64'd300);
`endif

        // bad magic only bumps err_magic and pkt_count
        send_pkt(32'h1234_5678, 32'd77, 16'd5, 64, 32'd0, 64'd0, 64'd999, 1'b0, 1'b0);
        idle(2);
        check_stats("magic");
        chk("magic:err_magic", {32'd0, err_magic}, 64'd1);

        // clear coincident with completion, then an arbitrary seq is not a seq error
        send_pkt(MAGIC, 32'd500, 16'd64, 64, 32'd0, 64'd0, 64'd5, 1'b1, 1'b0);
        idle(1);
        check_stats("clrhit");
        chk("clrhit:pkt_count", {32'd0, pkt_count}, 64'd0);
        send_pkt(MAGIC, 32'd900, 16'd32, 32, 32'd0, 64'd10, 64'd20, 1'b0, 1'b0);
        idle(2);
        check_stats("clrhit_next");
        chk("clrhit_next:err_seq", {32'd0, err_seq}, 64'd0);

        // reset mid-packet abandons the frame
        s_axis_tdata  = {112'd0, 64'd0, 16'd64, 32'd3, MAGIC};
        s_axis_tstrb  = 32'hFFFF_FFFF;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        @(negedge axi_aclk);
        axi_resetn = 1'b0;
        s_axis_tlast = 1'b1;
        @(negedge axi_aclk);
        axi_resetn = 1'b1;
        idle(3);
        model_clear();
        check_stats("midrst");
        send_pkt(MAGIC, 32'd42, 16'd64, 64, 32'd0, 64'd0, 64'd8, 1'b0, 1'b0);
        idle(2);
        check_stats("midrst_next");
        chk("midrst_next:pkt_count", {32'd0, pkt_count}, 64'd1);

        chk("sb:drained", 64'(sb_q.size()), 64'd0);
        chk("sb:done_count", 64'(dones), 64'(pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
